// File: rtl/synth_pkg.sv
// Shared constants for the synth tile: waveform modes, register field codes,
// ctrl bit layout and the noise LFSR definition.
package synth_pkg;

    typedef enum logic [2:0] {
        ModeSaw    = 3'd0,
        ModeSquare = 3'd1,
        ModeTri    = 3'd2,
        ModePulse  = 3'd3,
        ModeNoise  = 3'd4
    } mode_e;

    localparam logic [1:0] FieldFreq = 2'd0;
    localparam logic [1:0] FieldCtrl = 2'd1;
    localparam logic [1:0] FieldDuty = 2'd2;

    localparam int unsigned CtrlModeLsb   = 0;
    localparam int unsigned CtrlModeW     = 3;
    localparam int unsigned CtrlEnableBit = 3;
    localparam int unsigned CtrlSyncBit   = 4;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    localparam logic [15:0] LfsrSeed = 16'hACE1;
    localparam logic [15:0] LfsrTaps = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LfsrTaps : 16'h0000);
    endfunction

endpackage

// File: rtl/synth_voice_bank_if.sv
// Host register-write port of the voice bank (valid/ready).
interface synth_voice_bank_if #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned PHASE_W    = 16
);
    localparam int unsigned VoiceW = $clog2(NUM_VOICES);

    logic               wr_valid;
    logic               wr_ready;
    logic [VoiceW-1:0]  wr_voice;
    logic [1:0]         wr_field;
    logic [PHASE_W-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_voice,
        output wr_field,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_voice,
        input  wr_field,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/synth_wave_gen.sv
// Combinational waveform shaper: maps the top phase bits to an amplitude for
// the selected mode. Unknown modes produce silence.
module synth_wave_gen
    import synth_pkg::*;
#(
    parameter int unsigned WAVE_W = 8
) (
    input  logic [WAVE_W-1:0] p,
    input  logic [2:0]        mode,
    input  logic [WAVE_W-1:0] duty,
    input  logic [WAVE_W-1:0] noise,
    output logic [WAVE_W-1:0] wave
);

    logic [WAVE_W-1:0] p_dbl;

    assign p_dbl = {p[WAVE_W-2:0], 1'b0};

    always_comb begin
        wave = '0;
        case (mode_e'(mode))
            ModeSaw:    wave = p;
            ModeSquare: wave = p[WAVE_W-1] ? '1 : '0;
            ModeTri:    wave = p[WAVE_W-1] ? ~p_dbl : p_dbl;
            ModePulse:  wave = (p < duty) ? '1 : '0;
            ModeNoise:  wave = noise;
            default:    wave = '0;
        endcase
    end

endmodule

// File: rtl/synth_voice_bank.sv
// Time-multiplexed oscillator bank: one voice per clock, frame sum strobed out
// once per NUM_VOICES cycles. Optional noise mode: SYNTH_VOICE_BANK_NOISE_EN.
module synth_voice_bank
    import synth_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned PHASE_W    = 16,
    parameter int unsigned WAVE_W     = 8,
    parameter int unsigned OUT_W      = WAVE_W + $clog2(NUM_VOICES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    synth_voice_bank_if.slave    wr,
    output logic [OUT_W-1:0]     sample_out,
    output logic                 sample_valid
);

    localparam int unsigned VoiceW = $clog2(NUM_VOICES);
    localparam logic [VoiceW-1:0] LastVoice = VoiceW'(NUM_VOICES - 1);

    logic [VoiceW-1:0]     v_q, v_d;
    logic [PHASE_W-1:0]    freq_q  [NUM_VOICES];
    logic [PHASE_W-1:0]    freq_d  [NUM_VOICES];
    logic [PHASE_W-1:0]    phase_q [NUM_VOICES];
    logic [PHASE_W-1:0]    phase_d [NUM_VOICES];
    logic [2:0]            mode_q  [NUM_VOICES];
    logic [2:0]            mode_d  [NUM_VOICES];
    logic [WAVE_W-1:0]     duty_q  [NUM_VOICES];
    logic [WAVE_W-1:0]     duty_d  [NUM_VOICES];
    logic [NUM_VOICES-1:0] en_q, en_d;
    logic [OUT_W-1:0]      acc_q, acc_d;
    logic [OUT_W-1:0]      sample_q, sample_d;
    logic                  valid_q, valid_d;

    logic [WAVE_W-1:0] shaped;
    logic [WAVE_W-1:0] wave;
    logic [WAVE_W-1:0] noise;
    logic [OUT_W-1:0]  frame_sum;
    logic              end_of_frame;
    logic              voice_in_range;
    logic              wr_fire;

    // Stall only the voice sitting in the datapath, so a sync never races the phase update.
    assign wr.wr_ready     = !(ena && (wr.wr_voice == v_q));
    assign voice_in_range  = ({1'b0, wr.wr_voice} < (VoiceW + 1)'(NUM_VOICES));
    assign wr_fire         = wr.wr_valid && wr.wr_ready && voice_in_range;
    assign end_of_frame    = ena && (v_q == LastVoice);

    synth_wave_gen #(
        .WAVE_W (WAVE_W)
    ) u_wave_gen (
        .p     (phase_q[v_q][PHASE_W-1 -: WAVE_W]),
        .mode  (mode_q[v_q]),
        .duty  (duty_q[v_q]),
        .noise (noise),
        .wave  (shaped)
    );

    assign wave      = en_q[v_q] ? shaped : '0;
    assign frame_sum = acc_q + OUT_W'(wave);

`ifdef SYNTH_VOICE_BANK_NOISE_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (end_of_frame) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LfsrSeed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign noise = lfsr_q[15 -: WAVE_W];
`else
    // Without the noise build, mode 4 falls through to a constant-zero source.
    assign noise = '0;
`endif

    always_comb begin
        v_d      = v_q;
        acc_d    = acc_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        freq_d   = freq_q;
        phase_d  = phase_q;
        mode_d   = mode_q;
        duty_d   = duty_q;
        en_d     = en_q;

        if (ena) begin
            v_d          = (v_q == LastVoice) ? '0 : v_q + 1'b1;
            phase_d[v_q] = phase_q[v_q] + freq_q[v_q];
            if (end_of_frame) begin
                sample_d = frame_sum;
                valid_d  = 1'b1;
                acc_d    = '0;
            end else begin
                acc_d = frame_sum;
            end
        end

        if (wr_fire) begin
            unique case (wr.wr_field)
                FieldFreq: freq_d[wr.wr_voice] = wr.wr_data;
                FieldCtrl: begin
                    mode_d[wr.wr_voice]   = wr.wr_data[CtrlModeLsb +: CtrlModeW];
                    en_d[wr.wr_voice]     = wr.wr_data[CtrlEnableBit];
                    if (wr.wr_data[CtrlSyncBit]) begin
                        phase_d[wr.wr_voice] = '0;
                    end
                end
                FieldDuty: duty_d[wr.wr_voice] = wr.wr_data[WAVE_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q      <= '0;
            acc_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            en_q     <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                freq_q[i]  <= '0;
                phase_q[i] <= '0;
                mode_q[i]  <= '0;
                duty_q[i]  <= '0;
            end
        end else begin
            v_q      <= v_d;
            acc_q    <= acc_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            en_q     <= en_d;
            freq_q   <= freq_d;
            phase_q  <= phase_d;
            mode_q   <= mode_d;
            duty_q   <= duty_d;
        end
    end

    always_comb begin
        sample_out   = sample_q;
        sample_valid = valid_q;
    end

endmodule

// File: tb/tb_synth_voice_bank.sv
// Randomised scoreboard bench for synth_voice_bank (4 voices, 16-bit phase, 8-bit waves).
module tb_synth_voice_bank;

    localparam int NV    = 4;
    localparam int OUT_W = 10;

    typedef struct {
        int due;
        int val;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ena = 1'b0;
    logic [OUT_W-1:0] sample_out;
    logic             sample_valid;

    synth_voice_bank_if #(.NUM_VOICES(NV), .PHASE_W(16)) wr_if ();

    synth_voice_bank #(
        .NUM_VOICES (NV),
        .PHASE_W    (16),
        .WAVE_W     (8),
        .OUT_W      (OUT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .wr           (wr_if),
        .sample_out   (sample_out),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc_m  = 0;
    exp_t exp_q[$];

    // Reference model: architectural register state, scan position and frame sum.
    int freq_m[NV];
    int phase_m[NV];
    int mode_m[NV];
    int en_m[NV];
    int duty_m[NV];
    int v_m;
    int acc_m;
    int lfsr_m;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                      name, act, act, exp, exp, $time);
    endtask

    function automatic int shape_m(input int mode, input int p, input int duty, input int noise);
        case (mode)
            0: return p;
            1: return (p >= 128) ? 255 : 0;
            2: return (p < 128) ? 2 * p : 511 - 2 * p;
            3: return (p < duty) ? 255 : 0;
`ifdef SYNTH_VOICE_BANK_NOISE_EN
            4: return noise;
`endif
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            freq_m[i] = 0; phase_m[i] = 0; mode_m[i] = 0; en_m[i] = 0; duty_m[i] = 0;
        end
        v_m = 0; acc_m = 0; lfsr_m = 'hACE1;
        exp_q.delete();
    endtask

    // One clock: drive at negedge, check ready, advance the model at posedge.
    task automatic step(input bit en, input bit vld, input int voice, input int field,
                        input int data, output bit accepted);
        bit rdy;
        @(negedge clk);
        ena              = en;
        wr_if.wr_valid   = vld;
        wr_if.wr_voice   = 2'(voice);
        wr_if.wr_field   = 2'(field);
        wr_if.wr_data    = 16'(data);
        rdy              = !(en && voice == v_m);
        #1;
        chk("wr_ready", int'(wr_if.wr_ready), int'(rdy));
        accepted = vld && rdy;
        @(posedge clk);
        cyc_m++;
        if (en) begin
            int w;
            w = en_m[v_m] ? shape_m(mode_m[v_m], phase_m[v_m] >> 8, duty_m[v_m], lfsr_m >> 8)
                          : 0;
            phase_m[v_m] = (phase_m[v_m] + freq_m[v_m]) % 65536;
            acc_m += w;
            if (v_m == NV - 1) begin
                exp_q.push_back('{due: cyc_m, val: acc_m});
                acc_m = 0;
                lfsr_m = (lfsr_m & 1) ? ((lfsr_m >> 1) ^ 'hB400) : (lfsr_m >> 1);
            end
            v_m = (v_m + 1) % NV;
        end
        if (accepted) begin
            case (field)
                0: freq_m[voice] = data & 'hFFFF;
                1: begin
                    mode_m[voice] = data & 7;
                    en_m[voice]   = (data >> 3) & 1;
                    if ((data >> 4) & 1) phase_m[voice] = 0;
                end
                2: duty_m[voice] = data & 'hFF;
                default: ;
            endcase
        end
    endtask

    task automatic idle(input bit en, input int n);
        bit a;
        for (int i = 0; i < n; i++) step(en, 1'b0, $urandom_range(0, NV - 1), 0, 0, a);
    endtask

    task automatic write(input bit en, input int voice, input int field, input int data);
        bit a = 1'b0;
        for (int t = 0; t < 8 && !a; t++) step(en, 1'b1, voice, field, data, a);
        chk("write_accepted", int'(a), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        ena = 1'b0;
        wr_if.wr_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_sample_out", int'(sample_out), 0);
        chk("reset_sample_valid", int'(sample_valid), 0);
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Monitor: every strobe must match the oldest expected frame, on its due cycle.
    always @(negedge clk) begin
        if (rst_n && sample_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", int'(sample_out), -1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("strobe_cycle", cyc_m, e.due);
                chk("sample_out", int'(sample_out), e.val);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_voice = '0;
        wr_if.wr_field = '0;
        wr_if.wr_data  = '0;
        model_reset();
        #12 rst_n = 1'b1;
        #1;
        chk("init_sample_out", int'(sample_out), 0);
        chk("init_sample_valid", int'(sample_valid), 0);

        // Idle scan: zero samples, ready tracks the scan position.
        idle(1'b1, 16);

        // Saw on voice 0 through phase wrap, then a square on voice 1.
        write(1'b1, 0, 0, 'h0100);
        write(1'b1, 0, 1, 'h08);
        idle(1'b1, 260 * NV);
        write(1'b1, 1, 0, 'h8000);
        write(1'b1, 1, 1, 'h09);
        idle(1'b1, 8 * NV);

        // Four synced saws at near-full rate: sum reaches 4x255 without overflow.
        for (int i = 0; i < NV; i++) write(1'b1, i, 0, 'hFF00);
        for (int i = 0; i < NV; i++) write(1'b1, i, 1, 'h18);
        idle(1'b1, 6 * NV);

        // Frozen scan: no strobes, writes always accepted.
        idle(1'b0, 10);
        write(1'b0, 2, 2, 'h40);

        // Randomised traffic across all fields, modes and enable patterns.
        for (int i = 0; i < 1500; i++) begin
            int f;
            int d;
            f = $urandom_range(0, 3);
            d = (f == 1) ? $urandom_range(0, 31) : $urandom_range(0, 65535);
            step($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, NV - 1), f, d, a);
        end

        // Reset mid-frame discards the partial sum; next frame restarts at voice 0.
        idle(1'b1, 2);
        do_reset();
        idle(1'b1, 3 * NV);

        // Noise voice configured while frozen, so the first frame sees the seed.
        do_reset();
        write(1'b0, 0, 1, 'h0C);
        idle(1'b1, 12 * NV);

        idle(1'b0, 2);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
